// File: rtl/alu_byte_sequencer_pkg.sv
// Shared encodings for the byte-serial ALU sequencer and the 8-bit alu_module it drives.
// The opcode encoding is the one alu_module decodes.
package alu_byte_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_ZERO = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } seq_state_e;

  // Carry out of bit 7 recovered from the operand MSBs and the sum MSB.
  function automatic logic byte_carry(input logic a7, input logic b7, input logic y7);
    return (a7 & b7) | ((a7 | b7) & ~y7);
  endfunction

endpackage

// File: rtl/alu_module.sv
// 8-bit combinational ALU driven by alu_byte_sequencer: PASS A, ADD A+B+CY, SUB A-B, ZERO.
// ST flags signed overflow of the add or subtract.
module alu_module
  import alu_byte_sequencer_pkg::*;
(
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       CY,
  input  logic [1:0] OP,
  output logic [7:0] Y,
  output logic       ST
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    Y  = '0;
    ST = 1'b0;
    case (alu_op_e'(OP))
      OP_PASS: Y = A;
      OP_ADD: begin
        Y  = A + B + {7'b0, CY};
        ST = (A[7] == B[7]) && (Y[7] != A[7]);
      end
      OP_SUB: begin
        Y  = A - B;
        ST = (A[7] != B[7]) && (Y[7] != A[7]);
      end
      default: Y = '0;
    endcase
  end

endmodule

// File: rtl/alu_byte_sequencer.sv
// Streams one wide command through the external 8-bit ALU, LSB byte first, chaining carry,
// and returns the assembled result with carry-out and signed overflow on a valid/ready response.
module alu_byte_sequencer
  import alu_byte_sequencer_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [8*NBYTES-1:0]   cmd_a,
  input  logic [8*NBYTES-1:0]   cmd_b,
  input  logic                  cmd_cin,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_cy,
  output logic [1:0]            alu_op,
  input  logic [7:0]            alu_y,
  input  logic                  alu_st,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_y,
  output logic                  rsp_cout,
  output logic                  rsp_ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  seq_state_e    state_q;
  alu_op_e       op_q;
  alu_op_e       cmd_op_e;
  logic [IW-1:0] idx_q;
  logic [IW+2:0] base;
  logic [W-1:0]  a_q, b_q, acc_q, acc_d, rsp_y_q;
  logic          carry_q, carry_d, ovf_run_q;
  logic          rsp_cout_q, rsp_ovf_q;
  logic          cmd_ready_q, rsp_valid_q;
  logic          op_is_arith;

  assign cmd_op_e    = alu_op_e'(cmd_op);
  assign op_is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign base        = {idx_q, 3'b000};

  // SUB is run through the ALU as an add of the pre-inverted B with carry-in 1.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_cy = 1'b0;
    alu_op = OP_PASS;
    if (state_q == S_RUN) begin
      alu_a  = a_q[base +: 8];
      alu_b  = b_q[base +: 8];
      alu_cy = carry_q;
      alu_op = op_is_arith ? OP_ADD : op_q;
    end
  end

  always_comb begin
    acc_d            = acc_q;
    acc_d[base +: 8] = alu_y;
    carry_d          = op_is_arith ? byte_carry(alu_a[7], alu_b[7], alu_y[7]) : 1'b0;
  end

  // DONE publishes the finished word one cycle after the last byte, then holds it for the handshake.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state is updated with <= so every branch sees pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_PASS;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      ovf_run_q   <= 1'b0;
      rsp_y_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q        <= cmd_op_e;
            a_q         <= cmd_a;
            b_q         <= (cmd_op_e == OP_SUB) ? ~cmd_b : cmd_b;
            carry_q     <= (cmd_op_e == OP_SUB) ? 1'b1 : ((cmd_op_e == OP_ADD) ? cmd_cin : 1'b0);
            idx_q       <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          carry_q <= carry_d;
          if (idx_q == LAST_IDX) begin
            ovf_run_q <= op_is_arith & alu_st;
            idx_q     <= '0;
            state_q   <= S_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DONE: begin
          if (!rsp_valid_q) begin
            rsp_y_q     <= acc_q;
            rsp_cout_q  <= carry_q;
            rsp_ovf_q   <= ovf_run_q;
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Bench for alu_byte_sequencer (NBYTES=4) with the real alu_module closing the loop; results are
// compared against a plain integer-arithmetic reference model and a table of known vectors.
module tb_alu_byte_sequencer;
  import alu_byte_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_cin;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [7:0]  alu_a, alu_b, alu_y;
  logic        alu_cy, alu_st;
  logic [1:0]  alu_op;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_ovf;
  logic [31:0] rsp_y;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_byte_sequencer #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cy(alu_cy), .alu_op(alu_op),
    .alu_y(alu_y), .alu_st(alu_st),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  alu_module u_alu (
    .A(alu_a), .B(alu_b), .CY(alu_cy), .OP(alu_op), .Y(alu_y), .ST(alu_st)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] y;
    logic        c, o;
  } vec_t;

  // Reference: whole-word integer arithmetic; returns {ovf, cout, y}.
  function automatic logic [33:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
    logic [32:0] s;
    longint      r;
    logic [31:0] y = '0;
    logic        c = 1'b0, o = 1'b0;
    case (op)
      2'b00: y = a;
      2'b01: begin
        s = {1'b0, a} + {1'b0, b} + {32'b0, cin};
        y = s[31:0];
        c = s[32];
        r = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      2'b10: begin
        y = a - b;
        c = (a >= b);
        r = longint'($signed(a)) - longint'($signed(b));
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      default: y = '0;
    endcase
    return {o, c, y};
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 40) begin
      @(posedge clk); @(negedge clk); n++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_ready_timeout: cmd_ready=%b, required 1 within 40 cycles", cmd_ready);
    end
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // lat counts rising edges since the accepting edge.
  task automatic wait_rsp(output logic [31:0] y, output logic c, output logic o, output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rsp_timeout: rsp_valid=%b, required 1 within 40 cycles", rsp_valid);
    end
    y = rsp_y; c = rsp_cout; o = rsp_ovf;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 32'h1; cmd_b = 32'h1;
    cmd_cin = 1'b1; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_cout, rsp_ovf} !== 4'b1000 || rsp_y !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready/valid/cout/ovf=%b y=%h, required 1000 y=00000000",
               {cmd_ready, rsp_valid, rsp_cout, rsp_ovf}, rsp_y);
    end
    vectors++;
    if ({alu_a, alu_b, alu_cy, alu_op} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_alu_idle: a=%h b=%h cy=%b op=%b, required all 0",
               alu_a, alu_b, alu_cy, alu_op);
    end
  endtask

  task automatic test_known_vectors();
    vec_t        tv[8];
    logic [31:0] y;
    logic        c, o;
    int          lat;
    tv[0] = '{2'b01, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    tv[1] = '{2'b01, 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1};
    tv[2] = '{2'b01, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tv[3] = '{2'b10, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    tv[4] = '{2'b10, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    tv[5] = '{2'b00, 32'hDEADBEEF, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    tv[6] = '{2'b11, 32'hDEADBEEF, 32'h12345678, 1'b1, 32'h00000000, 1'b0, 1'b0};
    tv[7] = '{2'b10, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b1, 1'b0};
    foreach (tv[i]) begin
      issue(tv[i].op, tv[i].a, tv[i].b, tv[i].cin);
      wait_rsp(y, c, o, lat);
      vectors++;
      if (y !== tv[i].y || c !== tv[i].c || o !== tv[i].o) begin
        miscompares++;
        $display("FAIL known_vec%0d: y=%h cout=%b ovf=%b, required y=%h cout=%b ovf=%b",
                 i, y, c, o, tv[i].y, tv[i].c, tv[i].o);
      end
      vectors++;
      if (lat != 5) begin
        miscompares++;
        $display("FAIL known_latency%0d: %0d edges, required 5", i, lat);
      end
      ack();
      vectors++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_y !== tv[i].y) begin
        miscompares++;
        $display("FAIL after_handshake%0d: ready=%b valid=%b y=%h, required 1 0 %h",
                 i, cmd_ready, rsp_valid, rsp_y, tv[i].y);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] y0, y1;
    logic        c0, o0, c1, o1;
    logic [33:0] exp1;
    int          lat;
    issue(2'b01, 32'h12345678, 32'h11111111, 1'b1);
    wait_rsp(y0, c0, o0, lat);
    cmd_op = 2'b10; cmd_a = 32'h00001000; cmd_b = 32'h00000001; cmd_cin = 1'b0;
    cmd_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_y !== y0 || rsp_cout !== c0 || rsp_ovf !== o0
          || cmd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: valid=%b y=%h ready=%b, required 1 %h 0",
                 j, rsp_valid, rsp_y, cmd_ready, y0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bubble_after_ack: ready=%b valid=%b, required 1 0", cmd_ready, rsp_valid);
    end
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL queued_accept: cmd_ready=%b, required 0", cmd_ready);
    end
    wait_rsp(y1, c1, o1, lat);
    exp1 = ref_model(2'b10, 32'h00001000, 32'h00000001, 1'b0);
    vectors++;
    if ({o1, c1, y1} !== exp1 || lat != 5) begin
      miscompares++;
      $display("FAIL queued_result: ovf/cout/y=%h lat=%0d, required %h lat=5",
               {o1, c1, y1}, lat, exp1);
    end
    ack();
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] a, y;
    logic        c, o;
    int          lat;
    bit          leaked = 1'b0;
    a = 32'hA5C3_7E19;
    issue(2'b10, a, 32'h0F0F0F0F, 1'b0);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    vectors++;
    if (alu_a !== a[23:16] || alu_op !== 2'b01) begin
      miscompares++;
      $display("FAIL run_byte2: alu_a=%h alu_op=%b, required %h 01", alu_a, alu_op, a[23:16]);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || {alu_a, alu_b, alu_cy, alu_op} !== 19'h0) begin
      miscompares++;
      $display("FAIL midrun_reset: ready=%b valid=%b a=%h b=%h cy=%b op=%b, required 1 0 and 0s",
               cmd_ready, rsp_valid, alu_a, alu_b, alu_cy, alu_op);
    end
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid !== 1'b0) leaked = 1'b1;
    end
    vectors++;
    if (leaked) begin
      miscompares++;
      $display("FAIL dropped_op_response: rsp_valid rose after reset, required 0");
    end
    issue(2'b01, 32'h1, 32'h1, 1'b0);
    wait_rsp(y, c, o, lat);
    vectors++;
    if (y !== 32'h2 || c !== 1'b0 || o !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_add: y=%h cout=%b ovf=%b, required 00000002 0 0", y, c, o);
    end
    ack();
  endtask

  task automatic test_random();
    logic [31:0] a, b, y;
    logic [1:0]  op;
    logic        cin, c, o;
    logic [33:0] exp;
    int          lat, hold;
    for (int i = 0; i < 60; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = ($urandom_range(0, 4) == 0) ? 32'h7FFFFFFF : $urandom;
      b   = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      cin = 1'($urandom_range(0, 1));
      exp = ref_model(op, a, b, cin);
      issue(op, a, b, cin);
      wait_rsp(y, c, o, lat);
      vectors++;
      if ({o, c, y} !== exp || lat != 5) begin
        miscompares++;
        $display("FAIL rand%0d op=%b a=%h b=%h cin=%b: ovf/cout/y=%h lat=%0d, required %h lat=5",
                 i, op, a, b, cin, {o, c, y}, lat, exp);
      end
      hold = $urandom_range(0, 3);
      for (int j = 0; j < hold; j++) begin
        @(posedge clk); @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_ovf, rsp_cout, rsp_y} !== {1'b1, exp} || cmd_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_hold%0d: valid/ovf/cout/y=%h ready=%b, required %h ready=0",
                   i, {rsp_valid, rsp_ovf, rsp_cout, rsp_y}, cmd_ready, {1'b1, exp});
        end
      end
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
